// File: rtl/poly_note_player_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : poly_note_player_pkg
//  Purpose  : Shared voice-state encoding, default sizes and mixer width
//             helper for the polyphonic note player.
//  Revision : 1.0  initial release
// ============================================================================
package poly_note_player_pkg;

  // Per-voice lifecycle.
  typedef enum logic [1:0] {
    V_IDLE = 2'd0,
    V_LOAD = 2'd1,
    V_PLAY = 2'd2,
    V_DONE = 2'd3
  } voice_state_t;

  localparam int DEFAULT_NUM_VOICES = 4;
  localparam int DEFAULT_SAMPLE_W   = 16;

  // Phase accumulator width inside every DDS.
  localparam int PHASE_W = 24;

  // Mixer accumulator width for the default configuration.
  localparam int MIX_W = DEFAULT_SAMPLE_W + $clog2(DEFAULT_NUM_VOICES);

  // Same rule, usable with a module's own parameter values.
  function automatic int mix_width(input int sample_w, input int num_voices);
    return sample_w + $clog2(num_voices);
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_note_player_voice.sv
`default_nettype none
// ============================================================================
//  Module   : note_voice (with frequency_rom and dds)
//  Purpose  : One voice slot: state machine, note register, beat counter,
//             registered frequency lookup and phase-accumulator oscillator.
//  Revision : 1.0  initial release
// ============================================================================

// Registered frequency lookup. The phase step equals the note index in units
// of 2^-NOTE_W of a waveform period per sample.
module frequency_rom #(
  parameter int NOTE_W  = 6,
  parameter int PHASE_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NOTE_W-1:0]  addr,
  output logic [PHASE_W-1:0] step
);

  // One-cycle registered fetch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) step <= '0;
    else       step <= {addr, {(PHASE_W-NOTE_W){1'b0}}};
  end

endmodule

// Phase accumulator producing a signed sawtooth from the phase MSBs.
// new_sample_ready follows sampling_pulse even while held, so every voice
// strobes in the same cycle regardless of its state.
module dds #(
  parameter int PHASE_W  = 24,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hold,
  input  logic [PHASE_W-1:0]         step,
  input  logic                       sampling_pulse,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       new_sample_ready
);

  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] phase_next;

  assign phase_next = phase + step;

  // Advance phase on each sample tick; hold clears the oscillator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase            <= '0;
      sample           <= '0;
      new_sample_ready <= 1'b0;
    end else begin
      new_sample_ready <= sampling_pulse;
      if (hold) begin
        phase  <= '0;
        sample <= '0;
      end else if (sampling_pulse) begin
        phase  <= phase_next;
        sample <= phase_next[PHASE_W-1 -: SAMPLE_W];
      end
    end
  end

endmodule

module note_voice
  import poly_note_player_pkg::*;
#(
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       load,
  input  logic [NOTE_W-1:0]          note_in,
  input  logic [DUR_W-1:0]           duration_in,
  input  logic                       beat,
  input  logic                       sampling_pulse,
  output logic                       idle,
  output logic                       playing,
  output logic                       finishing,
  output logic signed [SAMPLE_W-1:0] voice_sample,
  output logic                       sample_ready
);

  voice_state_t       state;
  voice_state_t       next_state;
  logic [NOTE_W-1:0]  note;
  logic [DUR_W-1:0]   count;
  logic [PHASE_W-1:0] step;
  logic               dds_hold;

  assign idle      = (state == V_IDLE);
  assign playing   = (state == V_PLAY);
  // Registered externally into done_mask; a flush never reports a finish.
  assign finishing = play_enable && (state == V_PLAY) && (count == '0);
  assign dds_hold  = !playing || !play_enable;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= V_IDLE;
    else       state <= next_state;
  end

  // Next-state logic; dropping play_enable returns the voice to IDLE.
  always_comb begin
    next_state = state;
    case (state)
      V_IDLE:  if (load) next_state = V_LOAD;
      V_LOAD:  next_state = V_PLAY;
      V_PLAY:  if (count == '0) next_state = V_DONE;
      V_DONE:  next_state = V_IDLE;
      default: next_state = V_IDLE;
    endcase
    if (!play_enable) next_state = V_IDLE;
  end

  // Note capture on allocation and beat countdown while playing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      note  <= '0;
      count <= '0;
    end else if (!play_enable) begin
      count <= '0;
    end else if (idle && load) begin
      note  <= note_in;
      count <= duration_in;
    end else if (playing && beat && (count != '0)) begin
      count <= count - DUR_W'(1);
    end
  end

  frequency_rom #(
    .NOTE_W  (NOTE_W),
    .PHASE_W (PHASE_W)
  ) u_rom (
    .clk   (clk),
    .reset (reset),
    .addr  (note),
    .step  (step)
  );

  dds #(
    .PHASE_W  (PHASE_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_dds (
    .clk              (clk),
    .reset            (reset),
    .hold             (dds_hold),
    .step             (step),
    .sampling_pulse   (sampling_pulse),
    .sample           (voice_sample),
    .new_sample_ready (sample_ready)
  );

endmodule
`default_nettype wire

// File: rtl/poly_note_player.sv
`default_nettype none
// ============================================================================
//  Module   : poly_note_player
//  Purpose  : Polyphonic note player: allocates incoming notes to the lowest
//             idle voice, mixes all playing voices and reports finished notes.
//  Revision : 1.0  initial release
// ============================================================================
module poly_note_player
  import poly_note_player_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6,
  parameter int SAMPLE_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play_enable,
  input  logic                       load_new_note,
  output logic                       load_ready,
  input  logic [NOTE_W-1:0]          note_to_load,
  input  logic [DUR_W-1:0]           duration_to_load,
  input  logic                       beat,
  input  logic                       sampling_pulse,
  output logic                       note_done,
  output logic [NUM_VOICES-1:0]      done_mask,
  output logic [NUM_VOICES-1:0]      voice_active,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic                       sample_ready
);

  localparam int LOG_V     = $clog2(NUM_VOICES);
  localparam int MIX_WIDTH = mix_width(SAMPLE_W, NUM_VOICES);

  logic [NUM_VOICES-1:0]      idle;
  logic [NUM_VOICES-1:0]      grant;
  logic [NUM_VOICES-1:0]      playing;
  logic [NUM_VOICES-1:0]      finishing;
  logic [NUM_VOICES-1:0]      dds_ready;
  logic signed [SAMPLE_W-1:0] voice_sample [NUM_VOICES];
  logic signed [MIX_WIDTH-1:0] mix_sum;
  logic                       accept;
  logic                       running;
  logic                       mix_strobe;

  // Holds load_ready low until the first edge after reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) running <= 1'b0;
    else       running <= 1'b1;
  end

  assign voice_active = ~idle;
  assign load_ready   = running && play_enable && (|idle);
  assign accept       = load_new_note && load_ready;
  // Isolate the lowest set bit: lowest-index idle voice wins.
  assign grant        = idle & (~idle + NUM_VOICES'(1));
  // Every DDS strobes in the same cycle, so the AND equals voice 0's strobe.
  assign mix_strobe   = &dds_ready;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    note_voice #(
      .NOTE_W   (NOTE_W),
      .DUR_W    (DUR_W),
      .SAMPLE_W (SAMPLE_W)
    ) u_voice (
      .clk            (clk),
      .reset          (reset),
      .play_enable    (play_enable),
      .load           (accept && grant[i]),
      .note_in        (note_to_load),
      .duration_in    (duration_to_load),
      .beat           (beat),
      .sampling_pulse (sampling_pulse),
      .idle           (idle[i]),
      .playing        (playing[i]),
      .finishing      (finishing[i]),
      .voice_sample   (voice_sample[i]),
      .sample_ready   (dds_ready[i])
    );
  end

  // Sum of sign-extended samples from voices that are actually playing.
  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (playing[i]) mix_sum = mix_sum + MIX_WIDTH'(voice_sample[i]);
    end
  end

  // Output sample register; scaling by the voice count cannot overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_ready <= 1'b0;
    end else if (!play_enable) begin
      sample       <= '0;
      sample_ready <= 1'b0;
    end else begin
      sample_ready <= mix_strobe;
      if (mix_strobe) sample <= SAMPLE_W'(mix_sum >>> LOG_V);
    end
  end

  // Registered completion report, one pulse for all simultaneous finishes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_mask <= '0;
      note_done <= 1'b0;
    end else begin
      done_mask <= finishing;
      note_done <= |finishing;
    end
  end

endmodule
`default_nettype wire

// File: doc/poly_note_player.md
# poly_note_player

Polyphonic successor to the single-voice note player. It accepts notes from the song reader on a ready/valid handshake and allocates each one to the lowest-numbered idle voice slot. Each voice times its own duration in beats and drives its own frequency-ROM lookup and DDS. All voice samples are mixed into one signed stream for the codec path, and every finished note is reported.

## Interface
Parameters:
- NUM_VOICES, 4, number of voice slots; power of two, 1..8
- NOTE_W, 6, note index width (frequency ROM address)
- DUR_W, 6, duration width in beats
- SAMPLE_W, 16, signed sample width from each DDS and at the output

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high; all state cleared immediately
- play_enable  in  1  low = synchronous flush of all voices
- load_new_note  in  1  valid for a note load
- load_ready  out  1  high when at least one voice is IDLE and play_enable=1
- note_to_load  in  NOTE_W  note index; sampled when the load is accepted
- duration_to_load  in  DUR_W  duration in beats; sampled when the load is accepted
- beat  in  1  one-cycle beat tick
- sampling_pulse  in  1  one-cycle sample-rate tick, forwarded to every DDS
- note_done  out  1  one-cycle pulse when any voice finishes
- done_mask  out  NUM_VOICES  voices finishing this cycle; valid with note_done
- voice_active  out  NUM_VOICES  bit i high when voice i is not IDLE
- sample  out  SAMPLE_W  signed mixed sample
- sample_ready  out  1  one-cycle strobe; sample updated this cycle

## Operation
- Load acceptance:
  - A load is accepted when load_new_note & load_ready.
  - The lowest-index IDLE voice captures note_to_load and duration_to_load into its note register and counter.
  - Exactly one voice is loaded per accepted load.
  - When load_ready is low, load_new_note is ignored; nothing is queued.
- Per-voice FSM, IDLE -> LOAD -> PLAY -> DONE -> IDLE:
  - IDLE: counter holds; DDS held in reset.
  - LOAD: one cycle. The registered ROM fetch completes. DDS still in reset. beat is ignored.
  - PLAY: DDS runs. If counter==0, next state is DONE. Otherwise beat decrements the counter.
  - DONE: one cycle. The voice's done_mask bit is set; next state is IDLE.
- A duration d plays for exactly d beats observed in PLAY. d=0 gives LOAD, one PLAY cycle, then DONE.
- note_done = |done_mask. Both are registered. Several voices finishing in the same cycle produce one pulse with several mask bits set.
- A voice in DONE is not allocatable. It becomes free the cycle after it enters IDLE.
- play_enable low:
  - All voices go to IDLE on the next edge.
  - Counters are cleared and all DDS are held in reset.
  - No done_mask or note_done is generated.
  - sample is forced to 0 and sample_ready is suppressed.
- Mixer:
  - Each voice's sample is masked to 0 unless that voice is in PLAY.
  - The masked samples are sign-extended to SAMPLE_W+log2(NUM_VOICES) and summed.
  - The sum is arithmetically shifted right by log2(NUM_VOICES), so no saturation is needed.
  - The result is registered into sample.
- Reset values: every voice IDLE, counters 0, note registers 0, sample 0, sample_ready 0, note_done 0, done_mask 0, voice_active 0, load_ready 0. load_ready rises on the first edge after reset deasserts if play_enable=1.

## Timing
- Load to audio: load accepted at edge N; LOAD during cycle N+1; PLAY from N+2. The DDS first responds to a sampling_pulse arriving in PLAY.
- Mixer latency: sample and sample_ready update one cycle after voice 0's DDS new_sample_ready. All DDS share sampling_pulse and assert new_sample_ready in the same cycle.
- Load and DONE in the same cycle: the finishing voice is not offered for allocation.
- Load and beat in the same cycle: the beat does not affect the newly loaded voice.
- play_enable low in the same cycle as a load: the load is not accepted (load_ready is low).
- Asynchronous reset mid-note: all outputs take their reset values at once, with no note_done.

## Structure
- Shared package holds:
  - voice state encoding (IDLE, LOAD, PLAY, DONE)
  - the localparam MIX_W = SAMPLE_W + $clog2(NUM_VOICES)
- Natural sub-module: note_voice. It contains the voice FSM, note register, beat counter, and instances of the existing frequency_rom and dds. The top level generates NUM_VOICES instances plus the allocator (priority encoder) and the mixer.

## Test plan
- Single note: note 10, duration 3, four beats spaced 20 cycles apart:
  - voice_active = 0001
  - note_done and done_mask = 0001 one cycle after the PLAY cycle that sees counter 0
  - voice 0 IDLE afterwards
- Fill all voices: four back-to-back loads with durations 2,2,2,2 -> voices 0..3 allocated in order, load_ready low after the fourth; a fifth load_new_note is ignored.
- Simultaneous finish: voices 1 and 2 loaded in the same beat window with duration 1 -> a single note_done pulse with done_mask = 0110.
- Duration 0: load note 5, duration 0 -> note_done exactly 3 cycles after acceptance, with no beat applied.
- Mixer: two voices forced to equal DDS output 0x4000, NUM_VOICES=4 -> sample = 0x2000; with only one active -> sample = 0x1000; with none active -> sample = 0.
- Flush and reset: drop play_enable, and separately assert reset, while three voices play -> voice_active = 0 and sample = 0, with no note_done in either case.
